// File: rtl/fb_write_arbiter_if.sv
// Bus bundle for the framebuffer write arbiter: SPI pixel input, scan-out read
// request, the shared RAM port, and bank/status flags.
interface fb_write_arbiter_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  pixel_clk;
  logic [15:0]           spi_data;
  logic                  spi_cs;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   ram_addr;
  logic                  ram_we;
  logic [15:0]           ram_wdata;
  logic                  display_bank;
  logic                  frame_done;
  logic                  overflow;

  modport slave (
    input  pixel_clk, spi_data, spi_cs, rd_req, rd_addr,
    output ram_addr, ram_we, ram_wdata, display_bank, frame_done, overflow
  );

  modport master (
    output pixel_clk, spi_data, spi_cs, rd_req, rd_addr,
    input  ram_addr, ram_we, ram_wdata, display_bank, frame_done, overflow
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Single-word holding buffer between the SPI receiver and the double-buffered
// framebuffer RAM port; scan-out reads always take priority over writes.
module fb_write_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int FRAME_PIXELS = 2048
) (
  input  logic                clk,
  input  logic                reset_n,
  fb_write_arbiter_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] FRAME_LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [2:0]            pclk_sync_r;
  logic [2:0]            cs_sync_r;
  logic                  cap_evt_s;
  logic                  sof_evt_s;
  logic                  write_go_s;

  logic [ADDR_WIDTH:0]   ram_addr_r,     ram_addr_n;
  logic                  ram_we_r,       ram_we_n;
  logic [15:0]           ram_wdata_r,    ram_wdata_n;
  logic                  display_bank_r, display_bank_n;
  logic                  frame_done_r,   frame_done_n;
  logic                  overflow_r,     overflow_n;
  logic                  write_bank_r,   write_bank_n;
  logic [ADDR_WIDTH-1:0] wr_ptr_r,       wr_ptr_n;
  logic [15:0]           hold_data_r,    hold_data_n;
  logic                  hold_valid_r,   hold_valid_n;

  // Two-flop synchronisers with a third stage for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pclk_sync_r <= 3'b000;
      cs_sync_r   <= 3'b000;
    end else begin
      pclk_sync_r <= {pclk_sync_r[1:0], bus.pixel_clk};
      cs_sync_r   <= {cs_sync_r[1:0], bus.spi_cs};
    end
  end

  assign cap_evt_s  = pclk_sync_r[1] & ~pclk_sync_r[2];
  assign sof_evt_s  = cs_sync_r[1] & ~cs_sync_r[2];
  // A start-of-frame suppresses any pending write in the same cycle
  assign write_go_s = ~bus.rd_req & hold_valid_r & ~sof_evt_s;

  // Next-state: RAM port arbitration, pointer/bank sequencing, capture buffer
  always_comb begin
    ram_addr_n     = ram_addr_r;
    ram_we_n       = 1'b0;
    ram_wdata_n    = ram_wdata_r;
    display_bank_n = display_bank_r;
    frame_done_n   = 1'b0;
    overflow_n     = overflow_r;
    write_bank_n   = write_bank_r;
    wr_ptr_n       = wr_ptr_r;
    hold_data_n    = hold_data_r;
    hold_valid_n   = hold_valid_r;

    if (bus.rd_req) begin
      ram_addr_n = {display_bank_r, bus.rd_addr};
    end else if (write_go_s) begin
      ram_addr_n   = {write_bank_r, wr_ptr_r};
      ram_we_n     = 1'b1;
      ram_wdata_n  = hold_data_r;
      hold_valid_n = 1'b0;
      if (wr_ptr_r == FRAME_LAST) begin
        wr_ptr_n       = {ADDR_WIDTH{1'b0}};
        display_bank_n = write_bank_r;
        write_bank_n   = ~write_bank_r;
        frame_done_n   = 1'b1;
      end else begin
        wr_ptr_n = wr_ptr_r + PTR_ONE;
      end
    end else begin
      ram_we_n = 1'b0;
    end

    // Capture after the write so a same-cycle write frees the buffer first
    if (sof_evt_s) begin
      wr_ptr_n     = {ADDR_WIDTH{1'b0}};
      hold_valid_n = 1'b0;
      overflow_n   = 1'b0;
    end else if (cap_evt_s) begin
      if (hold_valid_r && !write_go_s) begin
        overflow_n = 1'b1;
      end else begin
        hold_data_n  = bus.spi_data;
        hold_valid_n = 1'b1;
      end
    end else begin
      hold_data_n = hold_data_n;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r     <= {(ADDR_WIDTH+1){1'b0}};
      ram_we_r       <= 1'b0;
      ram_wdata_r    <= 16'h0000;
      display_bank_r <= 1'b1;
      frame_done_r   <= 1'b0;
      overflow_r     <= 1'b0;
      write_bank_r   <= 1'b0;
      wr_ptr_r       <= {ADDR_WIDTH{1'b0}};
      hold_data_r    <= 16'h0000;
      hold_valid_r   <= 1'b0;
    end else begin
      ram_addr_r     <= ram_addr_n;
      ram_we_r       <= ram_we_n;
      ram_wdata_r    <= ram_wdata_n;
      display_bank_r <= display_bank_n;
      frame_done_r   <= frame_done_n;
      overflow_r     <= overflow_n;
      write_bank_r   <= write_bank_n;
      wr_ptr_r       <= wr_ptr_n;
      hold_data_r    <= hold_data_n;
      hold_valid_r   <= hold_valid_n;
    end
  end

  assign bus.ram_addr     = ram_addr_r;
  assign bus.ram_we       = ram_we_r;
  assign bus.ram_wdata    = ram_wdata_r;
  assign bus.display_bank = display_bank_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.overflow     = overflow_r;

endmodule
